// File: rtl/lcd_timing_gen.sv
// RGB-LCD raster timing generator: HSYNC/VSYNC/DE plus active-area x/y, with an optional
// pixel clock-enable divider and frame-aligned start/stop of the raster.
module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2,
    parameter int unsigned PIX_DIV  = 1,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 9
) (
    input  logic          CLK_SYS,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic          LCD_HSYNC,
    output logic          LCD_VSYNC,
    output logic          LCD_DE,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;
    logic            w_ce;
    logic            w_emit;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_hs_act;
    logic            w_vs_act;
    logic            w_de;

    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_line_start;
    logic            r_frame_start;
    logic            r_running;

    generate
        if (PIX_DIV <= 1) begin : g_no_div
            assign w_ce = 1'b1;
        end else begin : g_div
            logic [DW-1:0] r_div;
            always_ff @(posedge CLK_SYS or negedge rst) begin
                if (!rst) begin
                    r_div <= '0;
                end else if (r_div == DW'(PIX_DIV - 1)) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            assign w_ce = (r_div == DW'(PIX_DIV - 1));
        end
    endgenerate

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_hs_act = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    assign w_vs_act = (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    assign w_de     = (r_h < H_ACT) && (r_v < V_ACT);

    // w_emit: the pixel at (r_h, r_v) is sent to the outputs on this edge.
    always_comb begin
        w_state_d = r_state;
        w_emit    = 1'b0;
        if (w_ce) begin
            unique case (r_state)
                StIdle: begin
                    if (en) begin
                        w_state_d = StRun;
                        w_emit    = 1'b1;
                    end
                end
                StRun, StDrain: begin
                    w_emit = 1'b1;
                    if (en) begin
                        w_state_d = StRun;
                    end else if (w_h_last && w_v_last) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StDrain;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_SYS or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_emit) begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge rst) begin
        if (!rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_line_start  <= w_emit && (r_h == '0);
            r_frame_start <= w_emit && (r_h == '0) && (r_v == '0);
            r_running     <= (w_state_d != StIdle);
            if (w_ce) begin
                if (w_emit) begin
                    r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
                    r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
                    r_de    <= w_de;
                    r_x     <= w_de ? XW'(r_h) : '0;
                    r_y     <= w_de ? YW'(r_v) : '0;
                end else begin
                    r_hsync <= ~SYNC_POL;
                    r_vsync <= ~SYNC_POL;
                    r_de    <= 1'b0;
                    r_x     <= '0;
                    r_y     <= '0;
                end
            end
        end
    end

    assign pix_ce      = w_ce;
    assign LCD_HSYNC   = r_hsync;
    assign LCD_VSYNC   = r_vsync;
    assign LCD_DE      = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = r_running;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: two small-raster instances (PIX_DIV 1 and 3) checked against a
// pixel-index model through an expected-output queue, plus directed window statistics.
module tb_lcd_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef logic [24:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic       ce_a, hs_a, vs_a, de_a, ls_a, fs_a, run_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic       ce_b, hs_b, vs_b, de_b, ls_b, fs_b, run_b;
    logic [9:0] x_b;
    logic [8:0] y_b;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_DIV(1), .SYNC_POL(1'b0), .XW(10), .YW(9)
    ) u_dut_a (
        .CLK_SYS(clk), .rst(rst), .en(en), .pix_ce(ce_a),
        .LCD_HSYNC(hs_a), .LCD_VSYNC(vs_a), .LCD_DE(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .running(run_a)
    );

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_DIV(3), .SYNC_POL(1'b0), .XW(10), .YW(9)
    ) u_dut_b (
        .CLK_SYS(clk), .rst(rst), .en(en), .pix_ce(ce_b),
        .LCD_HSYNC(hs_b), .LCD_VSYNC(vs_b), .LCD_DE(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b), .running(run_b)
    );

    int checks   = 0;
    int failures = 0;

    // Model state per instance: 0 idle, 1 run, 2 drain; p is the next pixel index in the frame.
    int   m_st[2];
    int   m_p[2];
    int   m_cnt[2];
    int   m_div[2];
    vec_t m_held[2];
    vec_t sb[$];

    int fs_cnt_a, de_cnt_a, runlow_a, hs_run_b, hs_last_b;

    function automatic vec_t idle_vec();
        return {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic vec_t pix_vec(int pp, bit run);
        int  h, v;
        bit  hact, vact, de;
        h    = pp % HT;
        v    = pp / HT;
        hact = (h >= HA + HF) && (h < HA + HF + HS);
        vact = (v >= VA + VF) && (v < VA + VF + VS);
        de   = (h < HA) && (v < VA);
        return {~hact, ~vact, de, de ? 10'(h) : 10'd0, de ? 9'(v) : 9'd0,
                (h == 0), (pp == 0), run};
    endfunction

    function automatic vec_t obs(int m);
        if (m == 0) return {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, run_a};
        return {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b, run_b};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m]   = 0;
            m_p[m]    = 0;
            m_cnt[m]  = 0;
            m_held[m] = idle_vec();
        end
    endtask

    task automatic check_reset_now(string tag);
        for (int m = 0; m < 2; m++) begin
            checks++;
            assert (obs(m) === idle_vec()) else begin
                failures++;
                $error("FAIL %s dut%0d observed=%h expected=%h", tag, m, obs(m), idle_vec());
            end
        end
    endtask

    // One clock: predict each instance's next outputs, queue them, then compare after the edge.
    task automatic tick();
        vec_t e;
        vec_t got;
        bit   ce_e;
        bit   ce_o;
        bit   last;
        for (int m = 0; m < 2; m++) begin
            ce_e = (m_cnt[m] == m_div[m] - 1);
            ce_o = (m == 0) ? ce_a : ce_b;
            checks++;
            assert (ce_o === ce_e) else begin
                failures++;
                $error("FAIL pix_ce dut%0d observed=%b expected=%b", m, ce_o, ce_e);
            end
            if (!rst) begin
                e = idle_vec();
            end else if (ce_e) begin
                if (m_st[m] != 0 || en) begin
                    last    = (m_p[m] == FR - 1);
                    m_st[m] = en ? 1 : (last ? 0 : 2);
                    e       = pix_vec(m_p[m], m_st[m] != 0);
                    m_p[m]  = (m_p[m] + 1) % FR;
                end else begin
                    e = idle_vec();
                end
            end else begin
                e      = m_held[m] & ~25'b110;
                e[0]   = (m_st[m] != 0);
            end
            if (rst) m_cnt[m] = (m_cnt[m] + 1) % m_div[m];
            m_held[m] = e;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            e   = sb.pop_front();
            got = obs(m);
            checks++;
            assert (got === e) else begin
                failures++;
                $error("FAIL raster dut%0d observed=%h expected=%h", m, got, e);
            end
        end
        fs_cnt_a += int'(fs_a);
        de_cnt_a += int'(de_a);
        runlow_a += int'(!run_a);
        if (!hs_b) begin
            hs_run_b++;
        end else if (hs_run_b > 0) begin
            hs_last_b = hs_run_b;
            hs_run_b  = 0;
        end
    endtask

    task automatic clear_stats();
        fs_cnt_a  = 0;
        de_cnt_a  = 0;
        runlow_a  = 0;
        hs_run_b  = 0;
        hs_last_b = 0;
    endtask

    task automatic check_int(string tag, int got, int want);
        checks++;
        assert (got == want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic wait_pixel_a(int target, string tag);
        int n;
        n = 0;
        while (m_p[0] != target && n < 400) begin
            tick();
            n++;
        end
        check_int(tag, m_p[0], target);
    endtask

    initial begin
        m_div[0] = 1;
        m_div[1] = 3;
        model_reset();
        clear_stats();

        // Reset held, then idle with en low.
        repeat (2) @(posedge clk);
        #1;
        check_reset_now("reset_values");
        rst = 1'b1;
        repeat (200) tick();
        check_int("idle_frame_starts", fs_cnt_a, 0);
        check_int("idle_running_low", runlow_a, 200);

        // Free-running raster: 360 cycles is exactly three PIX_DIV=1 frames.
        en = 1'b1;
        clear_stats();
        repeat (360) tick();
        check_int("frame_start_count_a", fs_cnt_a, 3);
        check_int("de_count_a", de_cnt_a, 3 * HA * VA);
        check_int("hsync_low_len_b", hs_last_b, 3 * HS);

        // Drop en at v=1, re-raise at v=2 while draining: no gap, only the natural frame_start.
        wait_pixel_a(HT, "reach_v1");
        clear_stats();
        en = 1'b0;
        wait_pixel_a(2 * HT, "reach_v2");
        en = 1'b1;
        repeat (100) tick();
        check_int("drain_rerun_frame_starts", fs_cnt_a, 1);
        check_int("drain_rerun_running_gap", runlow_a, 0);

        // Drop en for good: both instances finish their frame and go idle.
        en = 1'b0;
        repeat (450) tick();
        check_int("drained_running_a", int'(run_a), 0);
        check_int("drained_running_b", int'(run_b), 0);

        // Asynchronous reset mid-frame, then restart from h=0,v=0.
        en = 1'b1;
        wait_pixel_a(2 * HT + 5, "reach_mid_frame");
        #2;
        rst = 1'b0;
        #1;
        check_reset_now("async_reset_mid_frame");
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_int("restart_frame_start", int'(fs_a), 1);
        check_int("restart_x", int'(x_a), 0);
        check_int("restart_y", int'(y_a), 0);
        repeat (150) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
